block_ram_streamer: RTL and testbench

//   Downstream stage of the fscpu block RAM: reads a contiguous window of table entries

---
 rtl/block_ram_streamer_if.sv | 12 +
 rtl/block_ram_streamer.sv | 139 +++++++++++++
 tb/tb_block_ram_streamer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_ram_streamer_if.sv
// Valid/ready stream carrying one table entry per beat, with tlast on the final entry.
interface block_ram_streamer_if #(
  parameter int C_DATA_WIDTH = 8
);
  logic                    tvalid;
  logic [C_DATA_WIDTH-1:0] tdata;
  logic                    tlast;
  logic                    tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/block_ram_streamer.sv
// Streams a contiguous window of block-RAM entries out as a valid/ready stream,
// using a 1-cycle registered RAM read and a 2-entry output buffer.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | issuing reads and draining beats until the tlast beat handshakes
// S_DONE | one-cycle done pulse, busy still high
module block_ram_streamer #(
  parameter int C_DATA_WIDTH    = 8,
  parameter int C_ADDRESS_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [C_ADDRESS_WIDTH-1:0] base_addr,
  input  logic [C_ADDRESS_WIDTH:0]   length,
  output logic                       busy,
  output logic                       done,
  output logic                       ram_re,
  output logic [C_ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [C_DATA_WIDTH-1:0]    ram_q,
  block_ram_streamer_if.master       m_axis
);
  localparam int AW = C_ADDRESS_WIDTH;
  localparam int DW = C_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [AW:0]     issue_rem;
  logic [AW-1:0]   addr_r;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      occ;
  logic [DW-1:0]   buf0_data;
  logic [DW-1:0]   buf1_data;
  logic            buf0_last;
  logic            buf1_last;
  logic            pop;
  logic            push;
  logic            issue;

  assign pop  = (occ != 2'd0) && m_axis.tready;
  assign push = inflight;

  // Issue depends on this cycle's pop so a steady 1 beat/clk stream keeps the RAM busy.
  assign issue = (state == S_RUN) && (issue_rem != '0) &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign ram_re        = issue;
  assign ram_addr      = addr_r;
  assign m_axis.tvalid = (occ != 2'd0);
  assign m_axis.tdata  = buf0_data;
  assign m_axis.tlast  = buf0_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      issue_rem     <= '0;
      addr_r        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      occ           <= 2'd0;
      buf0_data     <= '0;
      buf1_data     <= '0;
      buf0_last     <= 1'b0;
      buf1_last     <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (issue_rem == (AW+1)'(1));

      if (issue) begin
        addr_r    <= addr_r + AW'(1);
        issue_rem <= issue_rem - (AW+1)'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            addr_r    <= base_addr;
            issue_rem <= length;
            if (length == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (pop && buf0_last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // buf0 is the head presented on the stream; buf1 only fills while buf0 is held
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            buf0_data <= ram_q;
            buf0_last <= inflight_last;
          end else begin
            buf1_data <= ram_q;
            buf1_last <= inflight_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0_data <= buf1_data;
          buf0_last <= buf1_last;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0_data <= ram_q;
            buf0_last <= inflight_last;
          end else begin
            buf0_data <= buf1_data;
            buf0_last <= buf1_last;
            buf1_data <= ram_q;
            buf1_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_block_ram_streamer.sv
// Scoreboard bench for block_ram_streamer with a 16-entry RAM model (RAM[i] = i + 0x10).
module tb_block_ram_streamer;
  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    int data;
    int last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  block_ram_streamer_if #(.C_DATA_WIDTH(DW)) m_axis ();

  block_ram_streamer #(.C_DATA_WIDTH(DW), .C_ADDRESS_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
    .m_axis    (m_axis)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_re) ram_q <= mem[ram_addr];

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];
  int    addr_q[$];
  int    outstanding = 0;
  int    beats_seen  = 0;
  bit    stalled     = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compares the stream head against the scoreboard and audits read issue.
  always @(negedge clk) begin
    int hs;
    if (reset) begin
      exp_q.delete();
      addr_q.delete();
      outstanding = 0;
      stalled     = 0;
    end else begin
      hs = (m_axis.tvalid && m_axis.tready) ? 1 : 0;
      if (stalled) check_val("tvalid_hold", int'(m_axis.tvalid), 1);
      if (m_axis.tvalid) begin
        if (exp_q.size() == 0) check_val("unexpected_beat", 1, 0);
        else begin
          check_val("tdata", int'(m_axis.tdata), exp_q[0].data);
          check_val("tlast", int'(m_axis.tlast), exp_q[0].last);
          if (hs != 0) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
      if (ram_re) begin
        if (addr_q.size() == 0) check_val("extra_ram_re", 1, 0);
        else check_val("ram_addr", int'(ram_addr), addr_q.pop_front());
        check_val("issue_limit", int'((outstanding - hs) < 2), 1);
      end
      outstanding = outstanding + int'(ram_re) - hs;
      stalled     = m_axis.tvalid && !m_axis.tready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives an accepted start and loads the expected beats and read addresses.
  task automatic do_start(input int b, input int len);
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW+1)'(len);
    for (int i = 0; i < len; i++) begin
      beat_t e;
      e.data = ((b + i) % 16) + 16;
      e.last = (i == len - 1) ? 1 : 0;
      exp_q.push_back(e);
      addr_q.push_back((b + i) % 16);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int found = 0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (done) begin
        found = 1;
        break;
      end
    end
    check_val("done_seen", found, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i + 16);
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    m_axis.tready = 1'b1;
    tick();
    tick();
    check_val("rst_busy",   int'(busy), 0);
    check_val("rst_done",   int'(done), 0);
    check_val("rst_ram_re", int'(ram_re), 0);
    check_val("rst_addr",   int'(ram_addr), 0);
    check_val("rst_tvalid", int'(m_axis.tvalid), 0);
    check_val("rst_tlast",  int'(m_axis.tlast), 0);
    check_val("rst_tdata",  int'(m_axis.tdata), 0);
    reset = 1'b0;
    tick();

    // basic window, latency and full throughput
    do_start(2, 4);
    check_val("t1_busy", int'(busy), 1);
    check_val("t1_re_first", int'(ram_re), 1);
    check_val("t1_tvalid_e0", int'(m_axis.tvalid), 0);
    tick();
    check_val("t1_tvalid_e1", int'(m_axis.tvalid), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("t1_beat_valid", int'(m_axis.tvalid), 1);
      check_val("t1_beat_last", int'(m_axis.tlast), (k == 3) ? 1 : 0);
    end
    tick();
    check_val("t1_done", int'(done), 1);
    check_val("t1_busy_done", int'(busy), 1);
    check_val("t1_tvalid_end", int'(m_axis.tvalid), 0);
    tick();
    check_val("t1_done_pulse", int'(done), 0);
    check_val("t1_busy_end", int'(busy), 0);

    // address wrap past the top of the table
    do_start(14, 4);
    wait_done(20);
    tick();

    // backpressure with tready pattern 1,0,0
    do_start(7, 5);
    begin
      int found = 0;
      for (int c = 0; c < 60; c++) begin
        m_axis.tready = (c % 3 == 0);
        tick();
        if (done) begin
          found = 1;
          break;
        end
      end
      check_val("t3_done_seen", found, 1);
    end
    m_axis.tready = 1'b1;
    tick();

    // random backpressure
    do_start(11, 9);
    begin
      int found = 0;
      for (int c = 0; c < 100; c++) begin
        m_axis.tready = 1'($urandom_range(0, 1));
        tick();
        if (done) begin
          found = 1;
          break;
        end
      end
      check_val("rnd_done_seen", found, 1);
    end
    m_axis.tready = 1'b1;
    tick();

    // zero length, then full table
    do_start(3, 0);
    check_val("t4_done_len0", int'(done), 1);
    check_val("t4_re_len0", int'(ram_re), 0);
    check_val("t4_tvalid_len0", int'(m_axis.tvalid), 0);
    tick();
    check_val("t4_busy_len0", int'(busy), 0);
    do_start(5, 16);
    wait_done(40);
    check_val("t4_sb_empty", exp_q.size(), 0);
    tick();

    // reset mid-window after two beats
    beats_seen = 0;
    do_start(3, 8);
    begin
      int got2 = 0;
      for (int c = 0; c < 20; c++) begin
        if (beats_seen >= 2) begin
          got2 = 1;
          break;
        end
        tick();
      end
      check_val("t5_two_beats", got2, 1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("t5_tvalid", int'(m_axis.tvalid), 0);
    check_val("t5_busy", int'(busy), 0);
    for (int c = 0; c < 3; c++) begin
      check_val("t5_no_done", int'(done), 0);
      tick();
    end
    do_start(9, 3);
    wait_done(20);
    tick();

    // start while busy is ignored
    do_start(0, 6);
    tick();
    start = 1'b1;
    base_addr = AW'(8);
    length = (AW+1)'(2);
    tick();
    start = 1'b0;
    wait_done(30);
    check_val("t6_sb_empty", exp_q.size(), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("t6_idle", int'(busy), 0);
    end
    check_val("t6_addr_q_empty", addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
